// File: rtl/spi_ep_sched.sv
// Byte-level SPI transfer sequencer: header decode, burst register reads/writes, one-byte read prefetch.
// Optional bus-timeout abort is enabled by defining SPI_EP_SCHED_TIMEOUT_EN.
module spi_ep_sched #(
    parameter int NUM_ENDPOINTS = 3,
    parameter int BUS_TIMEOUT   = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_ENDPOINTS-1:0]   epsel,
    input  logic                       spi_ctrl_si,
    input  logic                       spi_ctrl_so,
    input  logic                       spi_ctrl_hd,
    input  logic [7:0]                 spi_ctrl_di,
    output logic [7:0]                 spi_ctrl_do,
    output logic [NUM_ENDPOINTS-1:0]   ep_valid,
    output logic                       ep_write,
    output logic [6:0]                 ep_addr,
    output logic [7:0]                 ep_wdata,
    input  logic [NUM_ENDPOINTS-1:0]   ep_ready,
    input  logic [8*NUM_ENDPOINTS-1:0] ep_rdata,
    output logic                       err_overrun,
    output logic                       err_underrun,
    output logic                       err_timeout
);
    typedef enum logic [2:0] {IDLE, HDR, WRITE, READ, DROP} state_t;

    state_t     state;
    logic [2:0] ep_idx, bus_idx, sel_idx;
    logic [6:0] addr, issue_addr;
    logic [7:0] pf_data, bus_rdata, done_data;
    logic       pf_valid, bus_read, bus_discard;
    logic       start, header, data;
    logic       bus_busy, bus_rdy, bus_abort, bus_done;
    logic       issue_en, issue_write;

    if (NUM_ENDPOINTS < 1 || NUM_ENDPOINTS > 8 || BUS_TIMEOUT < 1) begin : g_param_check
        $error("spi_ep_sched: parameter out of range");
    end

    function automatic logic [NUM_ENDPOINTS-1:0] onehot(input logic [2:0] idx);
        logic [NUM_ENDPOINTS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_ENDPOINTS; i++) v[i] = (idx == 3'(i));
        return v;
    endfunction

    assign start    = spi_ctrl_so & spi_ctrl_hd & ~spi_ctrl_si;
    assign header   = spi_ctrl_si & spi_ctrl_hd;
    assign data     = spi_ctrl_si & ~spi_ctrl_hd;
    assign bus_busy = |ep_valid;
    assign bus_done = bus_busy & (bus_rdy | bus_abort);
    assign done_data = bus_rdy ? bus_rdata : 8'hEE;

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < NUM_ENDPOINTS; i++)
            if (epsel[i]) sel_idx = 3'(i);
    end

    // Only the lane of the endpoint owning the current op is observed.
    always_comb begin
        bus_rdy   = 1'b0;
        bus_rdata = 8'h00;
        for (int i = 0; i < NUM_ENDPOINTS; i++) begin
            if (bus_idx == 3'(i)) begin
                bus_rdy   = ep_ready[i];
                bus_rdata = ep_rdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        issue_en    = 1'b0;
        issue_write = 1'b0;
        issue_addr  = addr;
        if (!start && !bus_busy) begin
            case (state)
                HDR:     if (header && !spi_ctrl_di[7]) begin
                             issue_en   = 1'b1;
                             issue_addr = spi_ctrl_di[6:0];
                         end
                WRITE:   if (data) begin
                             issue_en    = 1'b1;
                             issue_write = 1'b1;
                         end
                READ:    issue_en = ~pf_valid;
                default: ;
            endcase
        end
    end

`ifdef SPI_EP_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(BUS_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    assign bus_abort = bus_busy & ~bus_rdy & (to_cnt == TO_W'(BUS_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            to_cnt <= (bus_busy && !bus_done) ? to_cnt + 1'b1 : '0;
            if (bus_abort)  err_timeout <= 1'b1;
            else if (start) err_timeout <= 1'b0;
        end
    end
`else
    assign bus_abort   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ep_idx       <= '0;
            bus_idx      <= '0;
            addr         <= '0;
            pf_data      <= '0;
            pf_valid     <= 1'b0;
            bus_read     <= 1'b0;
            bus_discard  <= 1'b0;
            spi_ctrl_do  <= '0;
            ep_valid     <= '0;
            ep_write     <= 1'b0;
            ep_addr      <= '0;
            ep_wdata     <= '0;
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            if (start) begin
                ep_idx       <= sel_idx;
                state        <= (epsel == '0) ? DROP : HDR;
                spi_ctrl_do  <= {err_timeout, err_underrun, err_overrun, 2'b00, sel_idx};
                err_overrun  <= 1'b0;
                err_underrun <= 1'b0;
                pf_valid     <= 1'b0;
                if (bus_busy) bus_discard <= 1'b1;
            end else begin
                case (state)
                    HDR: if (header) begin
                        addr <= spi_ctrl_di[6:0];
                        if (spi_ctrl_di[7]) begin
                            state       <= WRITE;
                            spi_ctrl_do <= 8'h00;
                        end else begin
                            state       <= READ;
                            spi_ctrl_do <= 8'hFF;
                        end
                    end
                    WRITE: if (data) begin
                        if (!bus_busy) begin
                            addr        <= addr + 7'd1;
                            spi_ctrl_do <= spi_ctrl_di;
                        end else begin
                            err_overrun <= 1'b1;
                        end
                    end
                    READ: if (spi_ctrl_so) begin
                        spi_ctrl_do <= pf_valid ? pf_data : 8'hFF;
                        pf_valid    <= 1'b0;
                        if (!pf_valid) err_underrun <= 1'b1;
                    end
                    DROP:    spi_ctrl_do <= 8'hFF;
                    default: ;
                endcase
            end

            if (issue_en) begin
                ep_valid    <= onehot(ep_idx);
                ep_write    <= issue_write;
                ep_addr     <= issue_addr;
                bus_idx     <= ep_idx;
                bus_read    <= ~issue_write;
                bus_discard <= 1'b0;
                if (issue_write) ep_wdata <= spi_ctrl_di;
            end

            // Completion after the so handling so a fill in the same cycle as an empty-so wins.
            if (bus_done) begin
                ep_valid <= '0;
                if (bus_read && !bus_discard && !start) begin
                    pf_data  <= done_data;
                    pf_valid <= 1'b1;
                    addr     <= addr + 7'd1;
                end
            end
        end
    end
endmodule
